dmem_responder: RTL and testbench

//  Responder for the processor's data-memory port: serves every lw/sw issued on

---
 rtl/dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM, TX stream FIFO, status/cycle-counter MMIO,
// all served through a single registered read port (q_dmem).
module dmem_responder #(
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned FIFO_BITS = 3,
  parameter logic [31:0] MMIO_BASE = 32'h0000FFF0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned RAM_DEPTH  = 2 ** ADDR_BITS;
  localparam int unsigned FIFO_DEPTH = 2 ** FIFO_BITS;
  localparam int unsigned CNT_W      = FIFO_BITS + 1;

  localparam logic [31:0] TX_ADDR     = MMIO_BASE;
  localparam logic [31:0] STATUS_ADDR = MMIO_BASE + 32'd1;
  localparam logic [31:0] CYCLES_ADDR = MMIO_BASE + 32'd2;
  localparam logic [31:0] CLEAR_ADDR  = MMIO_BASE + 32'd3;

  logic [31:0] ram      [RAM_DEPTH];
  logic [31:0] fifo_mem [FIFO_DEPTH];

  logic [FIFO_BITS-1:0] rd_ptr;
  logic [FIFO_BITS-1:0] wr_ptr;
  logic [CNT_W-1:0]     count;
  logic [31:0]          cycles;
  logic                 ovf;
  logic                 err;
  logic [7:0]           drop_cnt;

  logic                 is_ram;
  logic                 is_tx;
  logic                 is_status;
  logic                 is_cycles;
  logic                 is_clear;
  logic                 unmapped;
  logic                 full;
  logic                 pop;
  logic                 push_req;
  logic                 push_ok;
  logic                 drop;
  logic                 clear_w;
  logic [CNT_W-1:0]     count_nxt;
  logic [FIFO_BITS-1:0] rd_ptr_nxt;
  logic [31:0]          head_nxt;
  logic [31:0]          status_word;
  logic [31:0]          rd_val;

  // Address decode, FIFO handshake and read-data selection from pre-edge state
  always_comb begin
    is_ram      = address_dmem < 32'(RAM_DEPTH);
    is_tx       = address_dmem == TX_ADDR;
    is_status   = address_dmem == STATUS_ADDR;
    is_cycles   = address_dmem == CYCLES_ADDR;
    is_clear    = address_dmem == CLEAR_ADDR;
    unmapped    = !(is_ram || is_tx || is_status || is_cycles || is_clear);
    clear_w     = wren && is_clear;

    full        = count == CNT_W'(FIFO_DEPTH);
    pop         = tx_valid && tx_ready;
    push_req    = wren && is_tx;
    // A full FIFO still accepts a push when the head leaves on the same edge
    push_ok     = push_req && (!full || pop);
    drop        = push_req && !push_ok;
    count_nxt   = count + CNT_W'(push_ok) - CNT_W'(pop);
    rd_ptr_nxt  = rd_ptr + FIFO_BITS'(pop);
    // The new head can only be the word being written when the FIFO ends up with one entry
    head_nxt    = (push_ok && (wr_ptr == rd_ptr_nxt)) ? data : fifo_mem[rd_ptr_nxt];

    status_word = {8'h00, drop_cnt, 8'(count), 4'h0, err, ovf, (count == '0), full};

    rd_val = 32'h0;
    if (is_ram) begin
      rd_val = ram[address_dmem[ADDR_BITS-1:0]];
    end else if (is_status) begin
      rd_val = status_word;
    end else if (is_cycles) begin
      rd_val = cycles;
    end
  end

  // RAM store; not reset, read-before-write falls out of the registered read
  always_ff @(posedge clock) begin
    if (wren && is_ram) begin
      ram[address_dmem[ADDR_BITS-1:0]] <= data;
    end
  end

  // FIFO storage write; contents are only observable through tx_data
  always_ff @(posedge clock) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= data;
    end
  end

  // Control state, counters, sticky flags and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      cycles   <= 32'h0;
      ovf      <= 1'b0;
      err      <= 1'b0;
      drop_cnt <= 8'h00;
      q_dmem   <= 32'h0;
      tx_data  <= 32'h0;
      tx_valid <= 1'b0;
    end else begin
      q_dmem   <= rd_val;
      rd_ptr   <= rd_ptr_nxt;
      wr_ptr   <= wr_ptr + FIFO_BITS'(push_ok);
      count    <= count_nxt;
      tx_valid <= count_nxt != '0;
      tx_data  <= (count_nxt != '0) ? head_nxt : 32'h0;

      if (wren && is_cycles) begin
        cycles <= data;
      end else begin
        cycles <= cycles + 32'd1;
      end

      // New events take priority over a same-edge clear
      ovf <= drop || (ovf && !clear_w);
      err <= unmapped || (err && !clear_w);
      if (clear_w) begin
        drop_cnt <= 8'(drop);
      end else if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: constant-vector table, reset corner cases and a
// randomized run, all checked against a queue/array reference model.
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h0000FFF0;
  localparam logic [31:0] A_TX = BASE;
  localparam logic [31:0] A_ST = BASE + 32'd1;
  localparam logic [31:0] A_CY = BASE + 32'd2;
  localparam logic [31:0] A_CL = BASE + 32'd3;

  logic        clock;
  logic        reset;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(
    .ADDR_BITS(12),
    .FIFO_BITS(3),
    .MMIO_BASE(BASE)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .address_dmem(address_dmem),
    .data        (data),
    .wren        (wren),
    .q_dmem      (q_dmem),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state
  logic [31:0] ram_m [int unsigned];
  logic [31:0] fifo_m [$];
  logic [31:0] cyc_m;
  bit          ovf_m;
  bit          err_m;
  int          drop_m;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        w;
    logic        r;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a < 32'd4096) return ram_m.exists(a) ? ram_m[a] : 32'h0;
    if (a == A_ST) begin
      return {8'h00, 8'(drop_m), 8'(fifo_m.size()), 4'h0, err_m, ovf_m,
              fifo_m.size() == 0, fifo_m.size() == 8};
    end
    if (a == A_CY) return cyc_m;
    return 32'h0;
  endfunction

  // One clock of stimulus; model advances, then outputs are compared #1 after the edge
  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w,
                     input logic r, input string tag);
    logic [31:0] exp_q;
    bit          q_known;
    bit          pop;
    bit          is_map;
    address_dmem = a;
    data         = d;
    wren         = w;
    tx_ready     = r;
    q_known = (a >= 32'd4096) || ram_m.exists(a);
    exp_q   = model_read(a);
    pop     = (fifo_m.size() != 0) && r;
    is_map  = (a < 32'd4096) || ((a >= BASE) && (a <= A_CL));
    if (w && a == A_CL) begin
      ovf_m  = 1'b0;
      err_m  = 1'b0;
      drop_m = 0;
    end
    if (!is_map) err_m = 1'b1;
    if (pop) void'(fifo_m.pop_front());
    if (w && a == A_TX) begin
      if (fifo_m.size() < 8) fifo_m.push_back(d);
      else begin
        ovf_m = 1'b1;
        if (drop_m < 255) drop_m++;
      end
    end
    if (w && a == A_CY) cyc_m = d;
    else cyc_m = cyc_m + 32'd1;
    if (w && a < 32'd4096) ram_m[a] = d;
    @(posedge clock);
    #1;
    if (q_known) check({tag, " q_dmem"}, q_dmem, exp_q);
    check({tag, " tx_valid"}, 32'(tx_valid), 32'(fifo_m.size() != 0));
    if (fifo_m.size() != 0) check({tag, " tx_data"}, tx_data, fifo_m[0]);
  endtask

  // Assert reset between edges, confirm outputs clear at once, release after one edge
  task automatic do_reset(input string tag);
    reset        = 1'b0;
    address_dmem = 32'h0;
    data         = 32'h0;
    wren         = 1'b0;
    tx_ready     = 1'b0;
    #1;
    check({tag, " q_dmem immediate"}, q_dmem, 32'h0);
    check({tag, " tx_valid immediate"}, 32'(tx_valid), 32'h0);
    check({tag, " tx_data immediate"}, tx_data, 32'h0);
    fifo_m.delete();
    ovf_m  = 1'b0;
    err_m  = 1'b0;
    drop_m = 0;
    cyc_m  = 32'h0;
    @(posedge clock);
    #1;
    check({tag, " q_dmem held"}, q_dmem, 32'h0);
    check({tag, " tx_valid held"}, 32'(tx_valid), 32'h0);
    reset = 1'b1;
  endtask

  task automatic add_vec(input logic [31:0] a, input logic [31:0] d, input logic w,
                         input logic r, input logic c, input logic [31:0] e);
    vec_t v;
    v.a = a; v.d = d; v.w = w; v.r = r; v.chk = c; v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    reset        = 1'b1;
    address_dmem = 32'h0;
    data         = 32'h0;
    wren         = 1'b0;
    tx_ready     = 1'b0;
    #1;
    do_reset("por");

    for (int i = 0; i < 16; i++) cyc(32'(i), 32'h1000 + 32'(i), 1'b1, 1'b0, "raminit");

    // Store/load and read-before-write on one RAM word
    add_vec(32'd5, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0);
    add_vec(32'd5, 32'h0,        1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    add_vec(32'd5, 32'h12345678, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
    add_vec(32'd5, 32'h0,        1'b0, 1'b0, 1'b1, 32'h12345678);
    // Three pushes held back, then drained back to back
    add_vec(A_TX, 32'd1, 1'b1, 1'b0, 1'b1, 32'h0);
    add_vec(A_TX, 32'd2, 1'b1, 1'b0, 1'b1, 32'h0);
    add_vec(A_TX, 32'd3, 1'b1, 1'b0, 1'b1, 32'h0);
    add_vec(A_ST, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0300);
    add_vec(A_ST, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0300);
    add_vec(A_ST, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0200);
    add_vec(A_ST, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0100);
    add_vec(A_ST, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0002);
    // Overflow by one, then clear
    for (int i = 0; i < 9; i++) add_vec(A_TX, 32'd100 + 32'(i), 1'b1, 1'b0, 1'b1, 32'h0);
    add_vec(A_ST, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0001_0805);
    add_vec(A_CL, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'h0);
    add_vec(A_ST, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0801);
    // Push into a full FIFO while the head pops
    add_vec(A_TX, 32'hA5, 1'b1, 1'b1, 1'b1, 32'h0);
    add_vec(A_ST, 32'h0,  1'b0, 1'b0, 1'b1, 32'h0000_0801);
    for (int i = 0; i < 8; i++) add_vec(A_ST, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    add_vec(A_ST, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0002);
    // Cycle counter wrap, then an unmapped read
    add_vec(A_CY, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 32'h0);
    add_vec(A_CY, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE);
    add_vec(A_CY, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF);
    add_vec(A_CY, 32'h0, 1'b0, 1'b0, 1'b1, 32'h00000000);
    add_vec(32'h0000_8000, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    add_vec(A_ST, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_000A);
    add_vec(A_CL, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0);
    add_vec(A_ST, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0002);

    foreach (tbl[i]) begin
      cyc(tbl[i].a, tbl[i].d, tbl[i].w, tbl[i].r, $sformatf("vec%0d", i));
      if (tbl[i].chk) check($sformatf("vec%0d const", i), q_dmem, tbl[i].exp);
    end

    // Reset while the FIFO holds four words
    for (int i = 0; i < 4; i++) cyc(A_TX, 32'hC0 + 32'(i), 1'b1, 1'b0, "pre_rst push");
    cyc(A_ST, 32'h0, 1'b0, 1'b0, "pre_rst status");
    check("pre_rst status const", q_dmem, 32'h0000_0400);
    do_reset("midrst");
    cyc(A_ST, 32'h0, 1'b0, 1'b0, "post_rst status");
    check("post_rst status const", q_dmem, 32'h0000_0002);

    // Randomized traffic across RAM, MMIO and unmapped space
    for (int n = 0; n < 3000; n++) begin
      int unsigned sel;
      logic [31:0] a;
      logic        w;
      sel = $urandom_range(0, 9);
      if (sel < 5) a = 32'($urandom_range(0, 15));
      else if (sel < 9) a = BASE + 32'(sel - 5);
      else begin
        case ($urandom_range(0, 3))
          0:       a = 32'h0000_1000;
          1:       a = 32'h0000_8000;
          2:       a = BASE + 32'd4;
          default: a = 32'hFFFF_FFFF;
        endcase
      end
      w = (a == A_TX) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
      if (a == A_CL && $urandom_range(0, 3) != 0) w = 1'b0;
      cyc(a, $urandom, w, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
